// File: rtl/sysbus_arb.sv
// Two-master (CPU/DMA) bus arbiter: 1-cycle grant latency, CPU stalled via RDY while DMA owns the bus,
// DMA backpressured by grant deferral; define ARB_TIMEOUT_EN to add the dma_lock watchdog.
module sysbus_arb #(
    parameter int ADDR_W    = 32,
    parameter int DATA_W    = 16,
    parameter int MAX_BURST = 16,
    parameter int MIN_CPU   = 4,
    parameter int TIMEOUT   = 255
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [ADDR_W-1:0] cpu_ab,
    input  logic [DATA_W-1:0] cpu_do,
    input  logic              cpu_we,
    output logic              cpu_rdy,
    input  logic              dma_req,
    input  logic              dma_lock,
    input  logic [ADDR_W-1:0] dma_ab,
    input  logic [DATA_W-1:0] dma_do,
    input  logic              dma_we,
    output logic              dma_gnt,
    output logic [DATA_W-1:0] dma_rdata,
    output logic              dma_rvalid,
    output logic              dma_err,
    output logic [ADDR_W-1:0] bus_ab,
    output logic [DATA_W-1:0] bus_do,
    output logic              bus_we,
    input  logic [DATA_W-1:0] bus_di
);

    localparam int BW = (MAX_BURST > 1) ? $clog2(MAX_BURST) : 1;
    localparam int MW = $clog2(MIN_CPU + 1);
    localparam logic [BW-1:0] BURST_LAST = BW'(MAX_BURST - 1);
    localparam logic [MW-1:0] MIN_LOAD   = MW'(MIN_CPU);

    typedef enum logic [1:0] {
        ST_CPU      = 2'd0,
        ST_DMA      = 2'd1,
        ST_HANDBACK = 2'd2
    } state_e;

    state_e          state_q, state_d;
    logic [BW-1:0]   burstcnt_q, burstcnt_d;
    logic [MW-1:0]   mincnt_q, mincnt_d;
    logic            rvalid_q, rvalid_d;
    logic            burst_done;
    logic            tmo_hit;

    assign burst_done = (burstcnt_q == BURST_LAST);

`ifdef ARB_TIMEOUT_EN
    localparam int LW = $clog2(TIMEOUT + 1);

    logic [LW-1:0] lockcnt_q, lockcnt_d;
    logic          err_q, err_d;

    assign tmo_hit = (state_q == ST_DMA) && (lockcnt_q == LW'(TIMEOUT - 1));
    assign dma_err = err_q;

    always_comb begin
        lockcnt_d = '0;
        err_d     = err_q;
        if (state_q == ST_DMA) begin
            lockcnt_d = (lockcnt_q == LW'(TIMEOUT)) ? lockcnt_q : lockcnt_q + LW'(1);
        end
        if (tmo_hit) begin
            err_d = 1'b1;
        end
        if (!dma_req) begin
            err_d = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            lockcnt_q <= '0;
            err_q     <= 1'b0;
        end else begin
            lockcnt_q <= lockcnt_d;
            err_q     <= err_d;
        end
    end
`else
    assign tmo_hit = 1'b0;
    assign dma_err = 1'b0;
`endif

    always_comb begin
        state_d    = state_q;
        burstcnt_d = burstcnt_q;
        mincnt_d   = mincnt_q;
        rvalid_d   = 1'b0;
        cpu_rdy    = 1'b0;
        dma_gnt    = 1'b0;
        bus_ab     = cpu_ab;
        bus_do     = cpu_do;
        bus_we     = 1'b0;

        case (state_q)
            ST_CPU: begin
                cpu_rdy = 1'b1;
                bus_we  = cpu_we;
                if (mincnt_q != '0) begin
                    mincnt_d = mincnt_q - MW'(1);
                end
                // A CPU write in flight is never cut off; the request is re-evaluated next cycle.
                if (dma_req && !cpu_we && (mincnt_q == '0)) begin
                    state_d = ST_DMA;
                end
            end
            ST_DMA: begin
                dma_gnt  = 1'b1;
                bus_ab   = dma_ab;
                bus_do   = dma_do;
                bus_we   = dma_we & dma_req;
                rvalid_d = dma_req & ~dma_we;
                if (!burst_done) begin
                    burstcnt_d = burstcnt_q + BW'(1);
                end
                // The hold-off starts counting in the handback cycle, so exactly MIN_CPU
                // RDY-high cycles precede the next grant.
                if (!dma_req || (burst_done && !dma_lock) || tmo_hit) begin
                    state_d  = ST_HANDBACK;
                    mincnt_d = MIN_LOAD;
                end
            end
            ST_HANDBACK: begin
                state_d    = ST_CPU;
                burstcnt_d = '0;
                if (mincnt_q != '0) begin
                    mincnt_d = mincnt_q - MW'(1);
                end
            end
            default: begin
                state_d = ST_CPU;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= ST_CPU;
            burstcnt_q <= '0;
            mincnt_q   <= '0;
            rvalid_q   <= 1'b0;
        end else begin
            state_q    <= state_d;
            burstcnt_q <= burstcnt_d;
            mincnt_q   <= mincnt_d;
            rvalid_q   <= rvalid_d;
        end
    end

    assign dma_rvalid = rvalid_q;
    assign dma_rdata  = bus_di;

endmodule

// File: tb/tb_sysbus_arb.sv
// Directed bench for sysbus_arb: reset, single read, write protection, burst limit, lock or timeout.
module tb_sysbus_arb;
    localparam int AW = 32;
    localparam int DW = 16;
    localparam int MB = 16;
    localparam int MC = 4;
    localparam int TO = 32;

    logic          clk = 1'b0;
    logic          reset;
    logic [AW-1:0] cpu_ab;
    logic [DW-1:0] cpu_do;
    logic          cpu_we;
    logic          cpu_rdy;
    logic          dma_req;
    logic          dma_lock;
    logic [AW-1:0] dma_ab;
    logic [DW-1:0] dma_do;
    logic          dma_we;
    logic          dma_gnt;
    logic [DW-1:0] dma_rdata;
    logic          dma_rvalid;
    logic          dma_err;
    logic [AW-1:0] bus_ab;
    logic [DW-1:0] bus_do;
    logic          bus_we;
    logic [DW-1:0] bus_di = '0;

    int tests_run    = 0;
    int tests_failed = 0;

    sysbus_arb #(
        .ADDR_W(AW), .DATA_W(DW), .MAX_BURST(MB), .MIN_CPU(MC), .TIMEOUT(TO)
    ) dut (
        .clk(clk), .reset(reset),
        .cpu_ab(cpu_ab), .cpu_do(cpu_do), .cpu_we(cpu_we), .cpu_rdy(cpu_rdy),
        .dma_req(dma_req), .dma_lock(dma_lock), .dma_ab(dma_ab), .dma_do(dma_do),
        .dma_we(dma_we), .dma_gnt(dma_gnt), .dma_rdata(dma_rdata),
        .dma_rvalid(dma_rvalid), .dma_err(dma_err),
        .bus_ab(bus_ab), .bus_do(bus_do), .bus_we(bus_we), .bus_di(bus_di)
    );

    always #5 clk = ~clk;

    // Registered bus memory: read data is a fold of the address seen one cycle earlier.
    always @(posedge clk) bus_di <= bus_ab[15:0] ^ bus_ab[31:16];

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic sample();
        @(negedge clk);
    endtask

    task automatic idle(input int n);
        dma_req  = 1'b0;
        dma_lock = 1'b0;
        cpu_we   = 1'b0;
        for (int i = 0; i < n; i++) next_cycle();
    endtask

    task automatic test_reset();
        sample();
        tests_run++; if (cpu_rdy !== 1'b1) begin tests_failed++; $display("FAIL reset_rdy got %b want 1", cpu_rdy); end
        tests_run++; if (dma_gnt !== 1'b0) begin tests_failed++; $display("FAIL reset_gnt got %b want 0", dma_gnt); end
        tests_run++; if (dma_rvalid !== 1'b0) begin tests_failed++; $display("FAIL reset_rvalid got %b want 0", dma_rvalid); end
        tests_run++; if (dma_err !== 1'b0) begin tests_failed++; $display("FAIL reset_err got %b want 0", dma_err); end
        tests_run++; if (bus_ab !== 32'h0000_1000) begin tests_failed++; $display("FAIL reset_bus_ab got %h want 00001000", bus_ab); end
        next_cycle();
        reset   = 1'b0;
        dma_req = 1'b1;
        dma_we  = 1'b0;
        dma_ab  = 32'h0000_4000;
        sample();
        next_cycle();
        sample();
        tests_run++; if (dma_gnt !== 1'b1) begin tests_failed++; $display("FAIL pre_reset_gnt got %b want 1", dma_gnt); end
        next_cycle();
        sample();
        tests_run++; if (dma_rvalid !== 1'b1) begin tests_failed++; $display("FAIL pre_reset_rvalid got %b want 1", dma_rvalid); end
        #1 reset = 1'b1;
        #1;
        tests_run++; if (cpu_rdy !== 1'b1) begin tests_failed++; $display("FAIL midreset_rdy got %b want 1", cpu_rdy); end
        tests_run++; if (dma_gnt !== 1'b0) begin tests_failed++; $display("FAIL midreset_gnt got %b want 0", dma_gnt); end
        tests_run++; if (bus_ab !== 32'h0000_1000) begin tests_failed++; $display("FAIL midreset_bus_ab got %h want 00001000", bus_ab); end
        tests_run++; if (dma_rvalid !== 1'b0) begin tests_failed++; $display("FAIL midreset_rvalid got %b want 0", dma_rvalid); end
        next_cycle();
        reset   = 1'b0;
        dma_req = 1'b0;
        sample();
        tests_run++; if (dma_gnt !== 1'b0) begin tests_failed++; $display("FAIL postreset_gnt got %b want 0", dma_gnt); end
        next_cycle();
        sample();
        tests_run++; if (dma_rvalid !== 1'b0) begin tests_failed++; $display("FAIL postreset_rvalid got %b want 0", dma_rvalid); end
    endtask

    task automatic test_single_read();
        int stall = 0;
        next_cycle();
        cpu_ab  = 32'h0000_2000;
        dma_req = 1'b1;
        dma_we  = 1'b0;
        dma_ab  = 32'hFFFD_0000;
        sample();
        tests_run++; if (dma_gnt !== 1'b0) begin tests_failed++; $display("FAIL rd_latency_gnt got %b want 0", dma_gnt); end
        next_cycle();
        sample();
        if (!cpu_rdy) stall++;
        tests_run++; if (dma_gnt !== 1'b1) begin tests_failed++; $display("FAIL rd_gnt got %b want 1", dma_gnt); end
        tests_run++; if (bus_ab !== 32'hFFFD_0000) begin tests_failed++; $display("FAIL rd_bus_ab got %h want fffd0000", bus_ab); end
        tests_run++; if (bus_we !== 1'b0) begin tests_failed++; $display("FAIL rd_bus_we got %b want 0", bus_we); end
        next_cycle();
        dma_req = 1'b0;
        sample();
        if (!cpu_rdy) stall++;
        tests_run++; if (dma_rvalid !== 1'b1) begin tests_failed++; $display("FAIL rd_rvalid got %b want 1", dma_rvalid); end
        tests_run++; if (dma_rdata !== 16'hFFFD) begin tests_failed++; $display("FAIL rd_rdata got %h want fffd", dma_rdata); end
        next_cycle();
        sample();
        if (!cpu_rdy) stall++;
        tests_run++; if (dma_gnt !== 1'b0) begin tests_failed++; $display("FAIL hb_gnt got %b want 0", dma_gnt); end
        tests_run++; if (bus_ab !== 32'h0000_2000) begin tests_failed++; $display("FAIL hb_bus_ab got %h want 00002000", bus_ab); end
        tests_run++; if (dma_rvalid !== 1'b0) begin tests_failed++; $display("FAIL hb_rvalid got %b want 0", dma_rvalid); end
        next_cycle();
        sample();
        tests_run++; if (cpu_rdy !== 1'b1) begin tests_failed++; $display("FAIL rd_rdy_back got %b want 1", cpu_rdy); end
        tests_run++; if (bus_di !== 16'h2000) begin tests_failed++; $display("FAIL rd_cpu_data got %h want 2000", bus_di); end
        tests_run++; if (stall !== 3) begin tests_failed++; $display("FAIL rd_stall got %0d want 3", stall); end
    endtask

    task automatic test_write_protect();
        idle(6);
        for (int i = 0; i < 3; i++) begin
            next_cycle();
            cpu_we  = 1'b1;
            cpu_ab  = 32'h0000_3000 + i;
            cpu_do  = 16'h1111;
            dma_req = 1'b1;
            dma_we  = 1'b1;
            dma_ab  = 32'h0000_5000;
            dma_do  = 16'h2222;
            sample();
            tests_run++; if (dma_gnt !== 1'b0) begin tests_failed++; $display("FAIL wp_gnt[%0d] got %b want 0", i, dma_gnt); end
            tests_run++; if (bus_we !== 1'b1) begin tests_failed++; $display("FAIL wp_we[%0d] got %b want 1", i, bus_we); end
            tests_run++; if (bus_ab !== 32'h0000_3000 + i) begin tests_failed++; $display("FAIL wp_ab[%0d] got %h want %h", i, bus_ab, 32'h0000_3000 + i); end
        end
        next_cycle();
        cpu_we = 1'b0;
        sample();
        tests_run++; if (dma_gnt !== 1'b0) begin tests_failed++; $display("FAIL wp_gnt_wefall got %b want 0", dma_gnt); end
        tests_run++; if (bus_we !== 1'b0) begin tests_failed++; $display("FAIL wp_we_wefall got %b want 0", bus_we); end
        next_cycle();
        sample();
        tests_run++; if (dma_gnt !== 1'b1) begin tests_failed++; $display("FAIL wp_gnt_late got %b want 1", dma_gnt); end
        tests_run++; if (bus_we !== 1'b1) begin tests_failed++; $display("FAIL wp_dma_we got %b want 1", bus_we); end
        tests_run++; if (bus_do !== 16'h2222) begin tests_failed++; $display("FAIL wp_dma_do got %h want 2222", bus_do); end
        next_cycle();
        dma_req = 1'b0;
        cpu_we  = 1'b1;
        cpu_ab  = 32'h0000_3100;
        sample();
        tests_run++; if (bus_we !== 1'b0) begin tests_failed++; $display("FAIL wp_noreq_we got %b want 0", bus_we); end
        next_cycle();
        sample();
        tests_run++; if (bus_we !== 1'b0) begin tests_failed++; $display("FAIL wp_hb_we got %b want 0", bus_we); end
        tests_run++; if (bus_ab !== 32'h0000_3100) begin tests_failed++; $display("FAIL wp_hb_ab got %h want 00003100", bus_ab); end
        next_cycle();
        sample();
        tests_run++; if (bus_we !== 1'b1) begin tests_failed++; $display("FAIL wp_cpu_we_back got %b want 1", bus_we); end
        next_cycle();
        cpu_we = 1'b0;
        dma_we = 1'b0;
    endtask

    task automatic test_burst_limit();
        logic [31:0] gnt_obs = '0, rdy_obs = '0, rv_obs = '0;
        logic [31:0] gnt_exp = '0, rdy_exp = '0, rv_exp = '0;
        logic [DW-1:0] last_rdata = '0;
        idle(6);
        next_cycle();
        dma_req  = 1'b1;
        dma_lock = 1'b0;
        dma_we   = 1'b0;
        dma_ab   = 32'h0001_0002;
        sample();
        gnt_obs[0] = dma_gnt; rdy_obs[0] = cpu_rdy; rv_obs[0] = dma_rvalid;
        for (int i = 1; i <= MB + MC + 2; i++) begin
            next_cycle();
            sample();
            gnt_obs[i] = dma_gnt; rdy_obs[i] = cpu_rdy; rv_obs[i] = dma_rvalid;
            if (i == MB + 1) last_rdata = dma_rdata;
        end
        for (int i = 0; i <= MB + MC + 2; i++) begin
            gnt_exp[i] = (i >= 1 && i <= MB) || (i == MB + MC + 2);
            rdy_exp[i] = (i == 0) || (i >= MB + 2 && i < MB + MC + 2);
            rv_exp[i]  = (i >= 2 && i <= MB + 1);
        end
        tests_run++; if (gnt_obs !== gnt_exp) begin tests_failed++; $display("FAIL burst_gnt got %h want %h", gnt_obs, gnt_exp); end
        tests_run++; if (rdy_obs !== rdy_exp) begin tests_failed++; $display("FAIL burst_rdy got %h want %h", rdy_obs, rdy_exp); end
        tests_run++; if (rv_obs !== rv_exp) begin tests_failed++; $display("FAIL burst_rvalid got %h want %h", rv_obs, rv_exp); end
        tests_run++; if (last_rdata !== 16'h0003) begin tests_failed++; $display("FAIL burst_hb_rdata got %h want 0003", last_rdata); end
        idle(8);
    endtask

`ifdef ARB_TIMEOUT_EN
    task automatic test_timeout();
        int dcyc = 0;
        idle(6);
        next_cycle();
        dma_req  = 1'b1;
        dma_lock = 1'b1;
        dma_we   = 1'b0;
        sample();
        tests_run++; if (dma_err !== 1'b0) begin tests_failed++; $display("FAIL to_err_start got %b want 0", dma_err); end
        for (int i = 1; i <= TO + 1; i++) begin
            next_cycle();
            sample();
            if (dma_gnt) dcyc++;
        end
        tests_run++; if (dcyc !== TO) begin tests_failed++; $display("FAIL to_dma_cycles got %0d want %0d", dcyc, TO); end
        tests_run++; if (cpu_rdy !== 1'b0 || dma_gnt !== 1'b0) begin tests_failed++; $display("FAIL to_handback got rdy=%b gnt=%b want 0 0", cpu_rdy, dma_gnt); end
        tests_run++; if (dma_err !== 1'b1) begin tests_failed++; $display("FAIL to_err_set got %b want 1", dma_err); end
        next_cycle();
        dma_req  = 1'b0;
        dma_lock = 1'b0;
        sample();
        tests_run++; if (dma_err !== 1'b1) begin tests_failed++; $display("FAIL to_err_sticky got %b want 1", dma_err); end
        next_cycle();
        sample();
        tests_run++; if (dma_err !== 1'b0) begin tests_failed++; $display("FAIL to_err_clear got %b want 0", dma_err); end
    endtask
`else
    task automatic test_lock();
        int xfers = 0;
        idle(6);
        next_cycle();
        dma_req  = 1'b1;
        dma_lock = 1'b1;
        dma_we   = 1'b0;
        sample();
        for (int i = 1; i <= 40; i++) begin
            next_cycle();
            sample();
            if (dma_gnt) xfers++;
        end
        tests_run++; if (xfers !== 40) begin tests_failed++; $display("FAIL lock_cycles got %0d want 40", xfers); end
        tests_run++; if (dma_err !== 1'b0) begin tests_failed++; $display("FAIL lock_err got %b want 0", dma_err); end
        next_cycle();
        dma_req  = 1'b0;
        dma_lock = 1'b0;
        sample();
        tests_run++; if (dma_gnt !== 1'b1) begin tests_failed++; $display("FAIL lock_release_gnt got %b want 1", dma_gnt); end
        next_cycle();
        sample();
        tests_run++; if (dma_gnt !== 1'b0 || cpu_rdy !== 1'b0) begin tests_failed++; $display("FAIL lock_hb got gnt=%b rdy=%b want 0 0", dma_gnt, cpu_rdy); end
        next_cycle();
        sample();
        tests_run++; if (cpu_rdy !== 1'b1) begin tests_failed++; $display("FAIL lock_rdy_back got %b want 1", cpu_rdy); end
    endtask
`endif

    initial begin
        reset    = 1'b1;
        cpu_ab   = 32'h0000_1000;
        cpu_do   = 16'h0000;
        cpu_we   = 1'b0;
        dma_req  = 1'b0;
        dma_lock = 1'b0;
        dma_ab   = '0;
        dma_do   = '0;
        dma_we   = 1'b0;
        test_reset();
        test_single_read();
        test_write_protect();
        test_burst_limit();
`ifdef ARB_TIMEOUT_EN
        test_timeout();
`else
        test_lock();
`endif
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
